// File: rtl/ps2_rx_controller_if.sv
// CPU-side peripheral bus of the PS/2 receive controller.
// master: address/read_en out, data/irq in. slave: the reverse.
interface ps2_rx_controller_if;
  logic [13:0] address;
  logic        read_en;
  logic [63:0] data;
  logic        irq;

  modport master (
    output address, read_en,
    input  data, irq
  );

  modport slave (
    input  address, read_en,
    output data, irq
  );
endinterface

// File: rtl/ps2_rx_controller.sv
// PS/2 receive controller: syncs PS2_clk/PS2_data, frames 11-bit
// PS/2 words, buffers scan codes in a FIFO, exposes data/status regs.
// Ports: system_clk, reset (async active-low), PS2_clk, PS2_data,
// bus (slave: address, read_en in; data, irq out).
// Option: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_rx_controller #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [13:0] DATA_ADDR      = 14'h3FF0,
  parameter logic [13:0] STATUS_ADDR    = 14'h3FF1,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic system_clk,
  input  logic reset,
  input  logic PS2_clk,
  input  logic PS2_data,
  ps2_rx_controller_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic ps2c_q1, ps2c_q2, ps2c_q3;
  logic ps2d_q1, ps2d_q2;
  logic fall, d_s;

  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  logic shift_en, cnt_clr, par_en;
  logic push_req, frame_set, par_set, tmo_set;
  logic par_ok;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, pop, push_ok, ov_set;

  logic       overflow_q, parity_err_q, frame_err_q, timeout_err_q;
  logic [7:0] err_count_q;
  logic       data_rd, stat_rd, err_inc;
  logic [63:0] stat_word;

  // Synchronisers idle high, matching the PS/2 bus idle level.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      ps2c_q1 <= 1'b1;
      ps2c_q2 <= 1'b1;
      ps2c_q3 <= 1'b1;
      ps2d_q1 <= 1'b1;
      ps2d_q2 <= 1'b1;
    end else begin
      ps2c_q1 <= PS2_clk;
      ps2c_q2 <= ps2c_q1;
      ps2c_q3 <= ps2c_q2;
      ps2d_q1 <= PS2_data;
      ps2d_q2 <= ps2d_q1;
    end
  end

  assign fall = ps2c_q3 & ~ps2c_q2;
  assign d_s  = ps2d_q2;

  assign tmo_hit = (state_q != IDLE) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  logic parity_unused;
  assign parity_unused = par_q;
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    par_en    = 1'b0;
    push_req  = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    tmo_set   = 1'b0;
    if (tmo_hit) begin
      state_d = IDLE;
      tmo_set = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!d_s) begin
            state_d = DATA;
            cnt_clr = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_en  = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!d_s)        frame_set = 1'b1;
          else if (par_ok) push_req  = 1'b1;
          else             par_set   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (state_q == IDLE || fall) tmo_q <= '0;
      else                         tmo_q <= tmo_q + TW'(1);
      if (cnt_clr)       bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 3'd1;
      // LSB arrives first, so shift in from the top.
      if (shift_en) shift_q <= {d_s, shift_q[7:1]};
      if (par_en)   par_q   <= d_s;
    end
  end

  assign data_rd = bus.read_en && (bus.address == DATA_ADDR);
  assign stat_rd = bus.read_en && (bus.address == STATUS_ADDR);

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = data_rd && (count_q != '0);
  // A concurrent pop frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req && (!full || pop);
  assign ov_set  = push_req && full && !pop;

  always_ff @(posedge system_clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push_ok) count_q <= count_q - CW'(1);
    end
  end

  assign err_inc = frame_set | par_set | tmo_set;

  // Sticky flags: set beats the clear-on-read of the status register.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      overflow_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      if (ov_set)       overflow_q <= 1'b1;
      else if (stat_rd) overflow_q <= 1'b0;
      if (frame_set)    frame_err_q <= 1'b1;
      else if (stat_rd) frame_err_q <= 1'b0;
      if (tmo_set)      timeout_err_q <= 1'b1;
      else if (stat_rd) timeout_err_q <= 1'b0;
      if (err_inc) begin
        if (stat_rd)                   err_count_q <= 8'd1;
        else if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end else if (stat_rd) begin
        err_count_q <= '0;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset)       parity_err_q <= 1'b0;
    else if (par_set) parity_err_q <= 1'b1;
    else if (stat_rd) parity_err_q <= 1'b0;
  end
`else
  assign parity_err_q = 1'b0;
`endif

  always_comb begin
    stat_word          = '0;
    stat_word[CW-1:0]  = count_q;
    stat_word[8]       = overflow_q;
    stat_word[9]       = parity_err_q;
    stat_word[10]      = frame_err_q;
    stat_word[11]      = timeout_err_q;
    stat_word[23:16]   = err_count_q;
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset)       bus.data <= '0;
    else if (pop)     bus.data <= {55'b0, 1'b1, mem[rd_ptr_q]};
    else if (stat_rd) bus.data <= stat_word;
    else              bus.data <= '0;
  end

  assign bus.irq = (count_q != '0);

endmodule

// File: doc/ps2_rx_controller.md
# ps2_rx_controller

Receive-side controller for the keyboard peripheral. It synchronises the PS/2 clock and data lines into the `system_clk` domain and sequences the 11-bit PS/2 frame with a state machine. Validated scan codes are buffered in a FIFO and exposed to the CPU through a memory-mapped data register and status register on the 14-bit peripheral address bus, with a 64-bit read data bus.

## Interface

- `FIFO_DEPTH`, 8, scan-code FIFO entries; power of two, 2..128.
- `DATA_ADDR`, 14'h3FF0, address of the scan-code pop register.
- `STATUS_ADDR`, 14'h3FF1, address of the status register.
- `TIMEOUT_CYCLES`, 5000, `system_clk` cycles without a PS/2 falling edge before an in-progress frame is aborted.

- `system_clk` in 1: the single clock. All state is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PS2_clk` in 1: PS/2 clock, asynchronous to `system_clk`.
- `PS2_data` in 1: PS/2 data, asynchronous to `system_clk`.
- `address` in 14: peripheral address.
- `read_en` in 1: read strobe, one cycle per access.
- `data` out 64: registered read data.
- `irq` out 1: high while the FIFO is non-empty.

## Operation

- **Synchronisers.** `PS2_clk` and `PS2_data` each pass through a 2-FF synchroniser.
- **Falling-edge detect.** A falling edge is flagged when the previous synced clock is 1 and the current synced clock is 0.
- **Sampling.** Data is sampled from the synced data line in the same cycle as the edge.
- **FSM states.** IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 (start bit), go to DATA and clear the bit counter. An edge with data=1 is ignored.
  - DATA: shift 8 bits in, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: data=1 gives a good frame, subject to parity. Data=0 sets `frame_err` and discards the frame. Either way, return to IDLE.
- **Parity.** Odd parity: the count of ones across the 8 data bits plus the parity bit must be odd.
- **Timeout.** A counter resets on every edge and only counts outside IDLE. When it reaches `TIMEOUT_CYCLES`, the frame is aborted, the FSM returns to IDLE and `timeout_err` is set.
- **FIFO push.** A good frame is pushed. If the FIFO is full, the code is dropped and `overflow` is set.
- **Error counter.** Every frame, parity or timeout error increments `err_count`, which is 8 bits and saturates at 255.
- **Reading `DATA_ADDR`.** Returns {55'b0, valid, code[7:0]}.
  - valid=1: the FIFO is non-empty and the head entry is popped.
  - Empty FIFO: returns 64'h0 and nothing changes.
- **Reading `STATUS_ADDR`.** Returns these fields; all other bits are 0:
  - [7:0] count
  - [8] overflow
  - [9] parity_err
  - [10] frame_err
  - [11] timeout_err
  - [23:16] err_count
- **Clear-on-read.** A status read clears bits [11:8] and `err_count`. If an error is set in the same cycle as the read, the set wins.
- **Other addresses.** Any other address, or `read_en`=0, loads `data` with 64'h0.
- **Reset values.** `data`=0, `irq`=0, FIFO empty, all flags and counters 0, FSM IDLE, synchronisers 1.

## Timing

- The `data` register is valid on the cycle after `read_en` (1-cycle latency).
- An edge is detected 2–3 `system_clk` cycles after `PS2_clk` falls.
- After the STOP edge, `count` and `irq` update on the next cycle.
- **Push and pop in the same cycle:**
  - Both occur and `count` is unchanged.
  - If the FIFO is full, the push is accepted and no overflow is flagged.
  - If the FIFO is empty, the read returns 0 and the pushed entry is retained.
- Pointers wrap modulo `FIFO_DEPTH`. `count` is log2(`FIFO_DEPTH`)+1 bits wide.
- Reset asserted mid-frame immediately discards the partial frame and FIFO contents.
- `system_clk` must be at least 8× `PS2_clk`.

## Configuration

- `PS2_PARITY_CHECK_EN` defined: a parity mismatch discards the frame, sets `parity_err` and increments `err_count`.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is captured but ignored, frames with a valid stop bit are always pushed, and status bit 9 reads 0.

## Test plan

1. **Good frame.** Send frame 0x1C, parity 0, stop 1. Required: status count=1 and `irq`=1. A DATA read then returns 64'h11C, after which count=0 and `irq`=0.
2. **Bad parity** (`PS2_PARITY_CHECK_EN` defined). Send 0x1C with parity 1. Required: no push; status reads 64'h0001_0200. A second status read returns 0.
3. **Overflow.** Send 9 good frames 0x01..0x09 with depth 8. Required: count=8 and bit8=1. Eight DATA reads return 0x101..0x108 in order; a ninth returns 0.
4. **Timeout.** Send start bit plus 3 data bits, then stop `PS2_clk`. Required: after `TIMEOUT_CYCLES`, bit11=1 and err_count=1. A following good frame 0x5A returns 0x15A.
5. **Reset mid-frame.** Assert `reset` after 5 data bits, then release. Required: all outputs are 0; the next frame 0x29 is received as 0x129.
6. **Simultaneous push and pop at full.** Pop while the STOP edge of a 9th frame completes. Required: count stays 8, overflow=0, and the 9th code is eventually read.
